// File: rtl/sys_feeder.sv
// Input FIFO and phase FSM feeding a systolic array: weight vectors go out unskewed,
// activation rows are skewed diagonally. Define SYS_FEEDER_ZERO_PAD_EN to zero invalid a_out rows.
module sys_feeder #(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ctrl_in,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_data,
    output logic [N*DW-1:0] w_out,
    output logic            w_valid,
    output logic [N*DW-1:0] a_out,
    output logic [N-1:0]    a_valid,
    output logic            done
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, LOAD_W, FEED, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [N*DW-1:0] mem_q [DEPTH];
    logic [AW:0]     wr_ptr_q, rd_ptr_q;
    logic            empty, full, push, pop_w, pop_a, pop;
    logic [N*DW-1:0] head;
    logic [CW-1:0]   w_cnt_q, w_cnt_d;
    logic [CW-1:0]   drain_cnt_q, drain_cnt_d;
    logic            done_q, done_d;
    logic [N*DW-1:0] w_out_q;
    logic            w_valid_q;
    logic [N-1:0]    row_vld;
    logic [N*DW-1:0] row_dat;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = pop_w || pop_a;
    assign head     = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        w_cnt_d     = w_cnt_q;
        drain_cnt_d = drain_cnt_q;
        done_d      = 1'b0;
        pop_w       = 1'b0;
        pop_a       = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctrl_in)     state_d = LOAD_W;
                else if (!empty) state_d = FEED;
            end
            LOAD_W: begin
                pop_w = !empty && (w_cnt_q < CW'(N));
                if (pop_w) w_cnt_d = w_cnt_q + 1'b1;
                if (!ctrl_in) begin
                    state_d = IDLE;
                    w_cnt_d = '0;
                end
            end
            FEED: begin
                pop_a = !empty;
                if (empty || ctrl_in) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == CW'(N - 1)) begin
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            w_cnt_q     <= '0;
            drain_cnt_q <= '0;
            done_q      <= 1'b0;
            w_out_q     <= '0;
            w_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_cnt_q     <= w_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            done_q      <= done_d;
            w_valid_q   <= pop_w;
            if (pop_w) w_out_q <= head;
        end
    end

    assign w_out   = w_out_q;
    assign w_valid = w_valid_q;
    assign done    = done_q;

    // Row gi is a chain of gi+1 stages; data only advances with its valid, so each stage holds its last value.
    for (genvar gi = 0; gi < N; gi++) begin : g_row
        if (gi == 0) begin : g_first
            logic [DW-1:0] dat_q;
            logic          vld_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    dat_q <= '0;
                    vld_q <= 1'b0;
                end else begin
                    vld_q <= pop_a;
                    if (pop_a) dat_q <= head[gi*DW +: DW];
                end
            end
            assign row_vld[gi]            = vld_q;
            assign row_dat[gi*DW +: DW]   = dat_q;
        end else begin : g_chain
            logic [DW-1:0] dat_q [gi+1];
            logic [gi:0]   vld_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k <= gi; k++) dat_q[k] <= '0;
                    vld_q <= '0;
                end else begin
                    vld_q <= {vld_q[gi-1:0], pop_a};
                    if (pop_a) dat_q[0] <= head[gi*DW +: DW];
                    for (int k = 1; k <= gi; k++) begin
                        if (vld_q[k-1]) dat_q[k] <= dat_q[k-1];
                    end
                end
            end
            assign row_vld[gi]            = vld_q[gi];
            assign row_dat[gi*DW +: DW]   = dat_q[gi];
        end
    end

    assign a_valid = row_vld;

`ifdef SYS_FEEDER_ZERO_PAD_EN
    for (genvar gi = 0; gi < N; gi++) begin : g_pad
        assign a_out[gi*DW +: DW] = row_vld[gi] ? row_dat[gi*DW +: DW] : '0;
    end
`else
    assign a_out = row_dat;
`endif

endmodule

// File: tb/tb_sys_feeder.sv
// Scoreboard bench for sys_feeder (N=4, DW=8, DEPTH=8): expected vectors are queued
// as they are pushed and consumed row by row as a_valid / w_valid fire.
module tb_sys_feeder;
    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
`ifdef SYS_FEEDER_ZERO_PAD_EN
    localparam bit ZP = 1'b1;
`else
    localparam bit ZP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            ctrl_in = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N*DW-1:0] in_data = '0;
    logic [N*DW-1:0] w_out;
    logic            w_valid;
    logic [N*DW-1:0] a_out;
    logic [N-1:0]    a_valid;
    logic            done;

    sys_feeder #(.N(N), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .w_out(w_out), .w_valid(w_valid), .a_out(a_out),
        .a_valid(a_valid), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int tests_run = 0;
    int tests_failed = 0;

    logic [N*DW-1:0] exp_vec[$];
    logic [N*DW-1:0] exp_w[$];
    int              rd_idx [N];
    int              av_cnt [N];
    int              wv_cnt = 0;
    int              done_cnt = 0;
    bit              mon_en = 1'b1;
    logic [N*DW-1:0] mon_vec;
    logic [DW-1:0]   mon_byte;

    // Scoreboard: every valid output row/weight is matched against the queued expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < N; i++) begin
                if (a_valid[i]) begin
                    av_cnt[i]++;
                    tests_run++;
                    if (rd_idx[i] >= exp_vec.size()) begin
                        tests_failed++;
                        $display("FAIL a_row%0d_extra: got %h, no output expected", i, a_out[i*DW +: DW]);
                    end else begin
                        mon_vec  = exp_vec[rd_idx[i]];
                        mon_byte = mon_vec[i*DW +: DW];
                        rd_idx[i]++;
                        $display("[TB] cyc %0d row%0d out %h", cyc, i, a_out[i*DW +: DW]);
                        if (a_out[i*DW +: DW] !== mon_byte) begin
                            tests_failed++;
                            $display("FAIL a_row%0d_data: got %h, expected %h", i, a_out[i*DW +: DW], mon_byte);
                        end
                    end
                end
            end
            if (w_valid) begin
                wv_cnt++;
                tests_run++;
                if (exp_w.size() == 0) begin
                    tests_failed++;
                    $display("FAIL w_extra: got %h, no weight expected", w_out);
                end else begin
                    mon_vec = exp_w.pop_front();
                    $display("[TB] cyc %0d weight out %h", cyc, w_out);
                    if (w_out !== mon_vec) begin
                        tests_failed++;
                        $display("FAIL w_data: got %h, expected %h", w_out, mon_vec);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                $display("[TB] cyc %0d done", cyc);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic bit all_consumed();
        for (int i = 0; i < N; i++) begin
            if (rd_idx[i] != exp_vec.size()) return 1'b0;
        end
        return (exp_w.size() == 0);
    endfunction

    task automatic clear_sb();
        exp_vec.delete();
        exp_w.delete();
        for (int i = 0; i < N; i++) begin
            rd_idx[i] = 0;
            av_cnt[i] = 0;
        end
        wv_cnt   = 0;
        done_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds in_valid until the vector is accepted; called #1 after a rising edge.
    task automatic push_one(input logic [N*DW-1:0] d);
        int k;
        in_data  = d;
        in_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 64) begin
            k++;
            @(negedge clk);
        end
        if (!in_ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL push_timeout: in_ready=%b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        $display("[TB] cyc %0d push %h", cyc, d);
    endtask

    task automatic wait_done(input int want);
        int k;
        k = 0;
        while (done_cnt < want && k < 300) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (done_cnt != want) begin
            tests_failed++;
            $display("FAIL done_count: got %0d pulses, expected %0d", done_cnt, want);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_sb();
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (a_out !== '0 || a_valid !== '0 || w_out !== '0 || w_valid !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: a_out=%h a_valid=%b w_out=%h w_valid=%b done=%b, expected all 0",
                     a_out, a_valid, w_out, w_valid, done);
        end
        // First push lands on the very first edge after release.
        in_data  = 32'hA4A3A2A1;
        in_valid = 1'b1;
        exp_vec.push_back(32'hA4A3A2A1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
        wait_done(1);
        tests_run++;
        if (!all_consumed()) begin
            tests_failed++;
            $display("FAIL reset_first_push: row0 consumed %0d of %0d, expected all", rd_idx[0], exp_vec.size());
        end
    endtask

    task automatic test_weight_load();
        clear_sb();
        ctrl_in = 1'b1;
        tick();
        for (int k = 1; k <= 5; k++) begin
            if (k <= N) exp_w.push_back({N{8'(k)}});
            push_one({N{8'(k)}});
        end
        repeat (6) tick();
        tests_run++;
        if (wv_cnt != N || exp_w.size() != 0) begin
            tests_failed++;
            $display("FAIL weight_count: got %0d w_valid cycles (%0d left), expected %0d", wv_cnt, exp_w.size(), N);
        end
        tests_run++;
        if (w_out !== {N{8'h04}} || w_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL weight_hold: w_out=%h w_valid=%b, expected %h and 0", w_out, w_valid, {N{8'h04}});
        end
        tests_run++;
        if (av_cnt[0] != 0) begin
            tests_failed++;
            $display("FAIL weight_no_feed: got %0d a_valid rows, expected 0", av_cnt[0]);
        end
        // The fifth vector stayed queued and now comes out as activations.
        exp_vec.push_back({N{8'h05}});
        ctrl_in = 1'b0;
        wait_done(1);
        tests_run++;
        if (!all_consumed()) begin
            tests_failed++;
            $display("FAIL weight_leftover: row0 consumed %0d of %0d, expected all", rd_idx[0], exp_vec.size());
        end
    endtask

    task automatic test_skew();
        int first_c [N];
        int cnt [N];
        int dcyc;
        logic [DW-1:0] held0;
        bit seen_held;
        clear_sb();
        for (int i = 0; i < N; i++) begin
            first_c[i] = -1;
            cnt[i] = 0;
        end
        dcyc = -1;
        held0 = '0;
        seen_held = 1'b0;
        ctrl_in = 1'b0;
        exp_vec.push_back(32'h40302010);
        push_one(32'h40302010);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (a_valid[i]) begin
                    if (first_c[i] < 0) first_c[i] = cyc;
                    cnt[i]++;
                end
            end
            if (a_valid[1] && !a_valid[0] && !seen_held) begin
                held0 = a_out[DW-1:0];
                seen_held = 1'b1;
            end
            if (done && dcyc < 0) dcyc = cyc;
        end
        for (int i = 0; i < N; i++) begin
            tests_run++;
            if (cnt[i] != 1 || first_c[i] != first_c[0] + i) begin
                tests_failed++;
                $display("FAIL skew_row%0d: valid %0d cycles at cyc %0d, expected 1 cycle at %0d",
                         i, cnt[i], first_c[i], first_c[0] + i);
            end
        end
        tests_run++;
        if (done_cnt != 1 || dcyc <= first_c[N-1]) begin
            tests_failed++;
            $display("FAIL skew_done: %0d pulses at cyc %0d, expected 1 after cyc %0d", done_cnt, dcyc, first_c[N-1]);
        end
        tests_run++;
        if (!seen_held || held0 !== (ZP ? 8'h00 : 8'h10)) begin
            tests_failed++;
            $display("FAIL skew_invalid_row0: got %h, expected %h", held0, (ZP ? 8'h00 : 8'h10));
        end
        tests_run++;
        if (a_out !== (ZP ? 32'h0 : 32'h40302010)) begin
            tests_failed++;
            $display("FAIL skew_idle_a_out: got %h, expected %h", a_out, (ZP ? 32'h0 : 32'h40302010));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_fifo();
        int bad;
        clear_sb();
        ctrl_in = 1'b1;
        tick();
        for (int k = 0; k < N; k++) begin
            exp_w.push_back({N{8'(8'h60 + k)}});
            push_one({N{8'(8'h60 + k)}});
        end
        for (int k = 0; k < DEPTH; k++) begin
            exp_vec.push_back({N{8'(8'h80 + k)}});
            push_one({N{8'(8'h80 + k)}});
        end
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_in_ready: got %b, expected 0", in_ready);
        end
        in_data  = {N{8'hEE}};
        in_valid = 1'b1;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (in_ready !== 1'b0) bad++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL full_ninth: in_ready high in %0d cycles, expected 0", bad);
        end
        ctrl_in = 1'b0;
        wait_done(1);
        tests_run++;
        if (!all_consumed() || av_cnt[N-1] != DEPTH) begin
            tests_failed++;
            $display("FAIL full_drain: row%0d gave %0d vectors, expected %0d", N-1, av_cnt[N-1], DEPTH);
        end
    endtask

    task automatic test_bubble_wrap();
        logic [N*DW-1:0] d;
        int k;
        clear_sb();
        ctrl_in = 1'b0;
        for (int v = 0; v < 12; v++) begin
            d = $urandom;
            exp_vec.push_back(d);
            push_one(d);
            repeat (v % 3) tick();
        end
        k = 0;
        while (!all_consumed() && k < 400) begin
            @(negedge clk);
            k++;
        end
        repeat (N + 4) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            tests_run++;
            if (av_cnt[i] != 12 || rd_idx[i] != 12) begin
                tests_failed++;
                $display("FAIL bubble_row%0d: got %0d valid cycles, expected 12", i, av_cnt[i]);
            end
        end
        tests_run++;
        if (done_cnt < 1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL bubble_done: %0d pulses, done now %b, expected >=1 and 0", done_cnt, done);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_feed();
        int bad;
        clear_sb();
        mon_en  = 1'b0;
        ctrl_in = 1'b0;
        push_one({N{8'h11}});
        push_one({N{8'h22}});
        push_one({N{8'h33}});
        tick();
        tick();
        rst = 1'b0;
        #1;
        tests_run++;
        if (a_out !== '0 || a_valid !== '0 || w_out !== '0 || w_valid !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: a_out=%h a_valid=%b w_out=%h w_valid=%b done=%b, expected all 0",
                     a_out, a_valid, w_out, w_valid, done);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done !== 1'b0 || a_valid !== '0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL midreset_quiet: %0d cycles with done/a_valid set, expected 0", bad);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_in_ready: got %b, expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        exp_vec.push_back(32'h5A6B7C8D);
        push_one(32'h5A6B7C8D);
        wait_done(1);
        tests_run++;
        if (!all_consumed()) begin
            tests_failed++;
            $display("FAIL midreset_recover: row0 consumed %0d of %0d, expected all", rd_idx[0], exp_vec.size());
        end
    endtask

    initial begin
        test_reset();
        test_weight_load();
        test_skew();
        test_full_fifo();
        test_bubble_wrap();
        test_reset_mid_feed();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sys_feeder.md
SYS_FEEDER -- requirements
Module: sys_feeder

Interface
REQ-001 Parameters SHALL be: N, default 4, array rows and columns; DW, default 8, element width; DEPTH, default 8, FIFO depth in vectors (power of 2, at least 2).
REQ-002 Ports SHALL be:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ctrl_in  in  1  phase from the systolic controller: 1 = weight load, 0 = compute.
- in_valid  in  1  upstream vector valid.
- in_ready  out  1  FIFO can accept.
- in_data  in  N*DW  vector; element i at bits [i*DW +: DW].
- w_out  out  N*DW  weight vector, unskewed.
- w_valid  out  1  w_out valid.
- a_out  out  N*DW  skewed activations; row i at [i*DW +: DW].
- a_valid  out  N  per-row valid.
- done  out  1  one-cycle pulse when drain completes.

Function
REQ-003 Transfer SHALL occur when in_valid && in_ready; in_ready = !full, independent of a same-cycle pop.
REQ-004 A pushed vector SHALL be poppable from the cycle after the push; FIFO depth SHALL be DEPTH; the pointers SHALL wrap modulo DEPTH.
REQ-005 FSM states SHALL be IDLE, LOAD_W, FEED and DRAIN; the reset state SHALL be IDLE.
REQ-006 IDLE transitions SHALL be:
- ctrl_in=1 -> LOAD_W.
- ctrl_in=0 and FIFO non-empty -> FEED.
- Otherwise, stay in IDLE.
REQ-007 LOAD_W behaviour SHALL be:
- Pop one vector per cycle while non-empty and w_cnt<N.
- A pop at cycle p SHALL drive w_out = vector and w_valid=1 at p+1.
- w_cnt SHALL saturate at N; further vectors stay in the FIFO.
- ctrl_in=0 -> IDLE, clearing w_cnt.
REQ-008 FEED behaviour SHALL be:
- Pop one vector per cycle while non-empty.
- Row i of a vector popped at cycle p SHALL appear on a_out row i with a_valid[i]=1 at cycle p+1+i.
- Row 0 SHALL have one register; row i SHALL have i+1 registers.
REQ-009 FEED SHALL go to DRAIN when the FIFO is empty or ctrl_in=1; the pop decision SHALL take precedence in the same cycle.
REQ-010 DRAIN behaviour SHALL be:
- No pops; the skew pipeline keeps shifting with zero valids entering.
- After exactly N cycles, pulse done=1 for one cycle and go to IDLE.
- in_ready SHALL still follow REQ-003 during DRAIN.
REQ-011 a_valid bits SHALL be 0 for every cycle and row carrying no popped data, including bubbles from an empty FIFO.
REQ-012 w_valid SHALL be 0 in every cycle with no LOAD_W pop in the previous cycle; w_out SHALL hold its last value.
REQ-013 An in_data change while in_ready=0 SHALL have no effect.

Reset
REQ-014 Asserting rst low SHALL immediately cause:
- state = IDLE, FIFO empty, w_cnt = 0.
- All skew registers and valids = 0.
- w_out = 0, a_out = 0, w_valid = 0, a_valid = 0, done = 0; in_ready = 1 after release.
REQ-015 Reset asserted mid-FEED or mid-DRAIN SHALL discard all in-flight data without a done pulse.
REQ-016 The first push SHALL be possible at the first rising edge with rst high.

Configuration
REQ-017 With SYS_FEEDER_ZERO_PAD_EN defined, a_out row i SHALL be forced to 0 whenever a_valid[i]=0.
REQ-018 Without SYS_FEEDER_ZERO_PAD_EN, a_out rows SHALL hold their last valid value whenever a_valid[i]=0.
REQ-019 Timing and valid behaviour SHALL be identical in both builds.

Verification (N=4, DW=8, DEPTH=8)
REQ-020 Weight load: ctrl_in=1, push 5 vectors 0x01..0x05 -> w_valid for exactly 4 cycles with 0x01..0x04; 0x05 remains in the FIFO.
REQ-021 Skew: ctrl_in=0, push one vector {0x40,0x30,0x20,0x10} popped at cycle p -> rows 0..3 valid at p+1..p+4 only, then done pulse after 4 drain cycles.
REQ-022 Full FIFO: hold the FIFO in LOAD_W with w_cnt=N, push 8 vectors -> in_ready=0 after the 8th; a 9th in_valid is not accepted; ctrl_in drop -> FEED drains all 8 in order.
REQ-023 Bubble and wrap: stream 12 vectors with in_valid toggling -> skewed output order preserved; a_valid gaps match the bubbles; pointer wrap is exercised.
REQ-024 Reset mid-FEED: assert rst with 3 vectors in flight -> all outputs 0 immediately; no done pulse; in_ready=1 after release.
REQ-025 ZERO_PAD: run REQ-021 in both builds -> the defined build shows 0 on invalid rows; the undefined build holds prior values; valids are identical.
